// File: rtl/score_uart_tx.sv
// score_uart_tx: reports game events to the host as 4-byte 8N1 UART messages
// (tag, tens ASCII, ones ASCII, line feed) with a one-deep pending slot.
module score_uart_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       death_evt,
    input  logic       win_evt,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_ones,
    output logic       tx,
    output logic       busy,
    output logic       dropped,
    output logic [7:0] msg_count
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BIT_RELOAD = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    shift;
    logic [7:0]    act_tens;
    logic [7:0]    act_ones;

    logic          pend_valid;
    logic [7:0]    pend_tag;
    logic [7:0]    pend_tens;
    logic [7:0]    pend_ones;

    logic          bit_end;
    logic          msg_end;
    logic          pop;
    logic          any_evt;
    logic          slot_free;
    logic          accept;
    logic          lost;
    logic [7:0]    evt_tag;
    logic [7:0]    next_byte;

    // Digits 0-9 map to ASCII '0'-'9'; anything else is shown as '?'.
    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        if (d <= 4'd9)
            return 8'h30 + {4'h0, d};
        else
            return 8'h3F;
    endfunction

    assign bit_end = (bit_cnt == '0);
    assign msg_end = (state == STOP) && bit_end && (byte_idx == 2'd3);

    // The slot is emptied on the edge the FSM starts the stored message,
    // so an event on that same edge can take its place.
    assign pop       = pend_valid && ((state == IDLE) || msg_end);
    assign any_evt   = win_evt || death_evt;
    assign slot_free = !pend_valid || pop;
    assign accept    = any_evt && slot_free;
    assign lost      = (win_evt && death_evt) || (any_evt && !slot_free);
    assign evt_tag   = win_evt ? 8'h57 : 8'h44;

    // Selects the byte that follows the one whose stop bit is ending.
    always_comb begin
        next_byte = 8'h0A;
        case (byte_idx)
            2'd0:    next_byte = act_tens;
            2'd1:    next_byte = act_ones;
            default: next_byte = 8'h0A;
        endcase
    end

    // Event capture into the pending slot and the sticky lost-event flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_tag   <= 8'h00;
            pend_tens  <= 8'h00;
            pend_ones  <= 8'h00;
            dropped    <= 1'b0;
        end else begin
            if (lost)
                dropped <= 1'b1;
            if (accept) begin
                pend_valid <= 1'b1;
                pend_tag   <= evt_tag;
                pend_tens  <= to_ascii(bcd_tens);
                pend_ones  <= to_ascii(bcd_ones);
            end else if (pop) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Frame FSM: shifts out start, 8 data bits LSB first and stop for each byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            shift     <= 8'h00;
            act_tens  <= 8'h00;
            act_ones  <= 8'h00;
            tx        <= 1'b1;
            busy      <= 1'b0;
            msg_count <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pend_valid) begin
                        act_tens <= pend_tens;
                        act_ones <= pend_ones;
                        shift    <= pend_tag;
                        byte_idx <= 2'd0;
                        bit_cnt  <= BIT_RELOAD;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= BIT_RELOAD;
                        bit_idx <= 3'd0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= BIT_RELOAD;
                        if (byte_idx == 2'd3) begin
                            msg_count <= msg_count + 8'd1;
                            if (pend_valid) begin
                                act_tens <= pend_tens;
                                act_ones <= pend_ones;
                                shift    <= pend_tag;
                                byte_idx <= 2'd0;
                                tx       <= 1'b0;
                                state    <= START;
                            end else begin
                                tx    <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            shift    <= next_byte;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_uart_tx.sv
// Testbench for score_uart_tx: table of single-message vectors plus hand-written
// sequences for back-to-back events, mid-frame reset and counter wrap.
module tb_score_uart_tx;

    localparam int DIV  = 16;
    localparam int DIV2 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       death_evt, win_evt;
    logic [3:0] bcd_tens, bcd_ones;
    logic       tx, busy, dropped;
    logic [7:0] msg_count;

    logic       death_evt2, win_evt2;
    logic [3:0] bcd_tens2, bcd_ones2;
    logic       tx2, busy2, dropped2;
    logic [7:0] msg_count2;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int busy_total = 0;

    int         rx_good2 = 0;
    int         rx_bad2  = 0;
    int         rx_idx2  = 0;
    bit         rx_act2  = 1'b0;
    int         rx_cnt2  = 0;
    logic [7:0] rx_byte2 = 8'h00;

    typedef struct {
        logic            w;
        logic            d;
        logic [3:0]      t;
        logic [3:0]      o;
        logic [0:3][7:0] exp;
        logic            exp_drop;
    } vec_t;

    vec_t vecs [4];

    score_uart_tx #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk(clk), .reset(reset), .death_evt(death_evt), .win_evt(win_evt),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .tx(tx), .busy(busy),
        .dropped(dropped), .msg_count(msg_count)
    );

    score_uart_tx #(.CLK_HZ(2), .BAUD(1)) dut2 (
        .clk(clk), .reset(reset), .death_evt(death_evt2), .win_evt(win_evt2),
        .bcd_tens(bcd_tens2), .bcd_ones(bcd_ones2), .tx(tx2), .busy(busy2),
        .dropped(dropped2), .msg_count(msg_count2)
    );

    always #5 clk = ~clk;

    // Free-running cycle and busy-high counters, sampled away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy === 1'b1)
            busy_total = busy_total + 1;
    end

    // Expected byte stream of the wrap test: "D00\n" repeated.
    function automatic logic [7:0] wrap_pat(input int idx);
        case (idx % 4)
            0:       return 8'h44;
            1:       return 8'h30;
            2:       return 8'h30;
            default: return 8'h0A;
        endcase
    endfunction

    // Receiver for the fast instance: samples each 2-clock bit on its first negedge.
    always @(negedge clk) begin
        if (!rx_act2) begin
            if (tx2 === 1'b0) begin
                rx_act2 = 1'b1;
                rx_cnt2 = 0;
            end
        end else begin
            rx_cnt2 = rx_cnt2 + 1;
            if (rx_cnt2 >= 2 && rx_cnt2 <= 16 && (rx_cnt2 % 2) == 0)
                rx_byte2[rx_cnt2 / 2 - 1] = tx2;
            if (rx_cnt2 == 18) begin
                if (tx2 === 1'b1 && rx_byte2 == wrap_pat(rx_idx2))
                    rx_good2 = rx_good2 + 1;
                else
                    rx_bad2 = rx_bad2 + 1;
                rx_idx2 = rx_idx2 + 1;
                rx_act2 = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp)
            n_pass = n_pass + 1;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic w, input logic d, input logic [3:0] t, input logic [3:0] o);
        @(posedge clk); #1;
        win_evt   = w;
        death_evt = d;
        bcd_tens  = t;
        bcd_ones  = o;
        @(posedge clk); #1;
        win_evt   = 1'b0;
        death_evt = 1'b0;
        bcd_tens  = 4'h5;
        bcd_ones  = 4'h5;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for a start bit, then samples every bit in its middle.
    task automatic recv_byte(output logic [7:0] b, output int t_start);
        int waited = 0;
        b = 8'h00;
        t_start = 0;
        while (tx !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            checkOutput("start_timeout", {31'd0, tx}, 32'd0);
            return;
        end
        t_start = cyc;
        repeat (DIV / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        checkOutput("stop_bit", {31'd0, tx}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int ts;
        int ts0, ts4;
        int base;
        int good_base, bad_base;
        logic [0:7][7:0] exp8;

        reset = 1'b1;
        win_evt = 1'b0; death_evt = 1'b0; bcd_tens = 4'h0; bcd_ones = 4'h0;
        win_evt2 = 1'b0; death_evt2 = 1'b0; bcd_tens2 = 4'h0; bcd_ones2 = 4'h0;

        vecs[0].w = 1'b0; vecs[0].d = 1'b1; vecs[0].t = 4'h0; vecs[0].o = 4'h7;
        vecs[0].exp = {8'h44, 8'h30, 8'h37, 8'h0A}; vecs[0].exp_drop = 1'b0;
        vecs[1].w = 1'b1; vecs[1].d = 1'b1; vecs[1].t = 4'h1; vecs[1].o = 4'h2;
        vecs[1].exp = {8'h57, 8'h31, 8'h32, 8'h0A}; vecs[1].exp_drop = 1'b1;
        vecs[2].w = 1'b0; vecs[2].d = 1'b1; vecs[2].t = 4'hA; vecs[2].o = 4'hF;
        vecs[2].exp = {8'h44, 8'h3F, 8'h3F, 8'h0A}; vecs[2].exp_drop = 1'b0;
        vecs[3].w = 1'b1; vecs[3].d = 1'b0; vecs[3].t = 4'h9; vecs[3].o = 4'h9;
        vecs[3].exp = {8'h57, 8'h39, 8'h39, 8'h0A}; vecs[3].exp_drop = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_tx", {31'd0, tx}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_dropped", {31'd0, dropped}, 32'd0);
        checkOutput("rst_msg_count", {24'd0, msg_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single-message table
        for (int i = 0; i < 4; i++) begin
            do_reset();
            base = busy_total;
            applyStimulus(vecs[i].w, vecs[i].d, vecs[i].t, vecs[i].o);
            @(negedge clk);
            checkOutput($sformatf("v%0d_tx_before_start", i), {31'd0, tx}, 32'd1);
            @(negedge clk);
            checkOutput($sformatf("v%0d_tx_start", i), {31'd0, tx}, 32'd0);
            for (int j = 0; j < 4; j++) begin
                recv_byte(b, ts);
                checkOutput($sformatf("v%0d_byte%0d", i, j), {24'd0, b}, {24'd0, vecs[i].exp[j]});
            end
            repeat (DIV) @(negedge clk);
            checkOutput($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
            checkOutput($sformatf("v%0d_msg_count", i), {24'd0, msg_count}, 32'd1);
            checkOutput($sformatf("v%0d_dropped", i), {31'd0, dropped}, {31'd0, vecs[i].exp_drop});
            checkOutput($sformatf("v%0d_busy_cycles", i), busy_total - base, 32'd640);
        end

        // Three deaths 10 cycles apart: two sent back to back, third lost
        do_reset();
        base = busy_total;
        exp8 = {8'h44, 8'h30, 8'h31, 8'h0A, 8'h44, 8'h30, 8'h32, 8'h0A};
        ts0 = 0;
        ts4 = 0;
        fork
            begin
                applyStimulus(1'b0, 1'b1, 4'h0, 4'h1);
                repeat (8) @(posedge clk);
                applyStimulus(1'b0, 1'b1, 4'h0, 4'h2);
                checkOutput("tri_dropped_after2", {31'd0, dropped}, 32'd0);
                repeat (8) @(posedge clk);
                applyStimulus(1'b0, 1'b1, 4'h0, 4'h3);
                checkOutput("tri_dropped_after3", {31'd0, dropped}, 32'd1);
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    recv_byte(b, ts);
                    if (j == 0) ts0 = ts;
                    if (j == 4) ts4 = ts;
                    checkOutput($sformatf("tri_byte%0d", j), {24'd0, b}, {24'd0, exp8[j]});
                end
            end
        join
        wait_idle("tri_idle_timeout");
        checkOutput("tri_msg_gap", ts4 - ts0, 32'd640);
        checkOutput("tri_msg_count", {24'd0, msg_count}, 32'd2);
        checkOutput("tri_busy_cycles", busy_total - base, 32'd1280);
        checkOutput("tri_dropped_end", {31'd0, dropped}, 32'd1);

        // Reset in the middle of a data bit of the third byte
        do_reset();
        applyStimulus(1'b0, 1'b1, 4'h1, 4'h1);
        repeat (2 * 10 * DIV + 4 * DIV) @(negedge clk);
        checkOutput("mid_busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_tx", {31'd0, tx}, 32'd1);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_msg_count", {24'd0, msg_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h4);
        exp8 = {8'h57, 8'h33, 8'h34, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int j = 0; j < 4; j++) begin
            recv_byte(b, ts);
            checkOutput($sformatf("mid_byte%0d", j), {24'd0, b}, {24'd0, exp8[j]});
        end
        wait_idle("mid_idle_timeout");
        checkOutput("mid_msg_count", {24'd0, msg_count}, 32'd1);

        // 256 back-to-back messages on the fast instance: counter wraps to zero
        do_reset();
        good_base = rx_good2;
        bad_base  = rx_bad2;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            death_evt2 = 1'b1;
            @(posedge clk); #1;
            death_evt2 = 1'b0;
            repeat (78) @(posedge clk);
        end
        #1;
        checkOutput("wrap_count_255", {24'd0, msg_count2}, 32'd255);
        begin
            int n = 0;
            while (busy2 !== 1'b0 && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("wrap_idle", {31'd0, busy2}, 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("wrap_msg_count", {24'd0, msg_count2}, 32'd0);
        checkOutput("wrap_dropped", {31'd0, dropped2}, 32'd0);
        checkOutput("wrap_good_bytes", rx_good2 - good_base, 32'd1024);
        checkOutput("wrap_bad_bytes", rx_bad2 - bad_base, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/score_uart_tx.md
# score_uart_tx

Serial transmitter that reports game events (player death, victory) with the current two-digit attempt count to a host PC over a single GPIO pin as 8N1 UART frames. It sits beside the attempts BCD counters and seven-segment decoders at top level, taking the same tens/ones BCD digits that drive HEX1/HEX0, and provides the outbound end of the board-to-host link.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- BAUD, 115200, line rate; bit period DIV = CLK_HZ / BAUD clocks, integer-truncated (434 at defaults); DIV ≥ 2 required.
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clock clk.
- death_evt  input  1  single-cycle pulse: player died.
- win_evt  input  1  single-cycle pulse: level won.
- bcd_tens  input  4  attempts tens digit, sampled on the event cycle.
- bcd_ones  input  4  attempts ones digit, sampled on the event cycle.
- tx  output  1  UART line, idle high; drives a GPIO pin.
- busy  output  1  high while a message is on the line or pending.
- dropped  output  1  sticky: an event was lost; cleared only by reset.
- msg_count  output  8  messages fully transmitted, wraps 255→0.

## Operation
- Message = 4 bytes back-to-back: tag, tens ASCII, ones ASCII, 0x0A.
  - Tag: 0x57 'W' for win, 0x44 'D' for death.
  - Digit byte = 0x30 + digit for 0–9; digit 10–15 sends 0x3F '?'.
- Byte frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly DIV clocks.
- FSM: IDLE → START → DATA (8 bits) → STOP → START of next byte (index 1–3) or, after byte 3, → IDLE (or START of pending message).
- Event capture: on an event cycle, tag and both digits are latched; later digit changes do not affect the message.
- Win and death asserted in the same cycle: win is accepted, death discarded, dropped set.
- One-deep pending slot: an event arriving while a message is active is stored if the slot is empty; otherwise it is discarded and dropped set. Pending is sent immediately after the active message.
- An event in the same cycle the final stop bit ends is treated as arriving while busy (goes to pending).
- msg_count increments on the cycle the 4th byte's stop bit completes.
- Reset values: tx=1, busy=0, dropped=0, msg_count=0, FSM IDLE, pending empty. Reset mid-frame aborts immediately; tx returns high asynchronously; the partial message is not counted.

## Timing
- tx is a registered output; no combinational path from inputs to tx.
- Event sampled at edge N (IDLE, empty): tx falls and busy rises after edge N+1; the start bit lasts DIV clocks.
- Bit k of a byte occupies clocks [(1+k)·DIV, (2+k)·DIV) relative to its start-bit edge; stop bit occupies [9·DIV, 10·DIV).
- Message length: 40·DIV clocks; no idle gap between bytes.
- Pending message: its start bit begins on the edge immediately after the previous stop bit ends (tx low 40·DIV clocks after the previous start).
- busy falls on the same edge that msg_count increments when pending is empty.
- Bit-period counter counts DIV-1 down to 0; it is reloaded at each bit boundary, no accumulated drift.

## Test plan
- CLK_HZ=16, BAUD=1 (DIV=16) for all cases; bench UART monitor samples mid-bit.
- Death pulse, tens=0, ones=7 → bytes 0x44,0x30,0x37,0x0A; tx low one cycle after pulse; busy high 640 clocks; msg_count=1; dropped=0.
- Win and death same cycle, tens=1, ones=2 → only 0x57,0x31,0x32,0x0A sent; dropped=1; msg_count=1.
- Three deaths (digits 0/1, 0/2, 0/3) at cycles 0, 10, 20 → messages "D01","D02" back-to-back (second start at clock 641), third lost; dropped=1; msg_count=2.
- Death with tens=0xA, ones=0xF → bytes 0x44,0x3F,0x3F,0x0A.
- Reset asserted mid-data-bit of byte 2 → tx=1 immediately, busy=0, msg_count=0; new win event afterwards transmits a full correct message.
- 256 back-to-back messages → msg_count wraps to 0, all frames well-formed.
